// File: rtl/pll_lock_qualifier_if.sv
// Signal bundle between the lock qualifier and its consumer: raw lock pin,
// count clear, and the qualified lock/status outputs.
interface pll_lock_qualifier_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 pll_locked_raw;
    logic                 clear_count;
    logic                 pll_locked;
    logic                 lock_lost;
    logic [CNT_WIDTH-1:0] lock_loss_count;
    logic [1:0]           state;

    modport master (
        output pll_locked_raw,
        output clear_count,
        input  pll_locked,
        input  lock_lost,
        input  lock_loss_count,
        input  state
    );

    modport slave (
        input  pll_locked_raw,
        input  clear_count,
        output pll_locked,
        output lock_lost,
        output lock_loss_count,
        output state
    );
endinterface

// File: rtl/pll_lock_qualifier.sv
// Qualifies the raw PLL LOCKED pin: synchronize, require a stable lock window,
// filter short dropouts, hold off after a real loss and count losses.
module pll_lock_qualifier #(
    parameter int SYNC_STAGE     = 2,
    parameter int LOCK_CYCLES    = 1024,
    parameter int GLITCH_CYCLES  = 4,
    parameter int HOLDOFF_CYCLES = 256,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    pll_lock_qualifier_if.slave  bus
);
    localparam int MAX_LG  = (LOCK_CYCLES > GLITCH_CYCLES) ? LOCK_CYCLES : GLITCH_CYCLES;
    localparam int MAX_ALL = (MAX_LG > HOLDOFF_CYCLES) ? MAX_LG : HOLDOFF_CYCLES;
    localparam int TW      = $clog2(MAX_ALL + 1);
    localparam int GW      = $clog2(GLITCH_CYCLES + 1);

    localparam logic [TW-1:0]        LOCK_LAST   = TW'(LOCK_CYCLES - 1);
    localparam logic [TW-1:0]        HOLD_LAST   = TW'(HOLDOFF_CYCLES - 1);
    localparam logic [GW-1:0]        GLITCH_LAST = GW'(GLITCH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_QUALIFY  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOFF  = 2'd3
    } state_t;

    // A clear on the same edge as a loss keeps that loss, so the result is 1.
    function automatic logic [CNT_WIDTH-1:0] count_next(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 clr,
        input logic                 loss
    );
        logic [CNT_WIDTH-1:0] res;
        if (clr) begin
            if (loss) begin
                res = CNT_WIDTH'(1);
            end else begin
                res = {CNT_WIDTH{1'b0}};
            end
        end else if (loss && (cnt != CNT_MAX)) begin
            res = cnt + CNT_WIDTH'(1);
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    logic [SYNC_STAGE-1:0] sync_r;
    logic                  locked_s;
    state_t                state_r;
    state_t                state_nxt_s;
    logic [TW-1:0]         timer_r;
    logic [TW-1:0]         timer_nxt_s;
    logic [GW-1:0]         glitch_r;
    logic [GW-1:0]         glitch_nxt_s;
    logic                  loss_s;
    logic                  pll_locked_r;
    logic                  lock_lost_r;
    logic [CNT_WIDTH-1:0]  count_r;

    // Synchronizer chain; sync_r[0] is the asynchronous capture flop (false-path target).
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            sync_r <= {SYNC_STAGE{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGE-2:0], bus.pll_locked_raw};
        end
    end

    assign locked_s = sync_r[SYNC_STAGE-1];

    // Next-state, timer and glitch-filter logic.
    always_comb begin
        state_nxt_s  = state_r;
        timer_nxt_s  = timer_r;
        glitch_nxt_s = {GW{1'b0}};
        loss_s       = 1'b0;
        case (state_r)
            ST_UNLOCKED: begin
                timer_nxt_s = {TW{1'b0}};
                if (locked_s) begin
                    state_nxt_s = ST_QUALIFY;
                end else begin
                    state_nxt_s = ST_UNLOCKED;
                end
            end
            ST_QUALIFY: begin
                if (!locked_s) begin
                    state_nxt_s = ST_UNLOCKED;
                    timer_nxt_s = {TW{1'b0}};
                end else if (timer_r == LOCK_LAST) begin
                    state_nxt_s = ST_LOCKED;
                    timer_nxt_s = {TW{1'b0}};
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            ST_LOCKED: begin
                timer_nxt_s = {TW{1'b0}};
                if (locked_s) begin
                    glitch_nxt_s = {GW{1'b0}};
                end else if (glitch_r == GLITCH_LAST) begin
                    loss_s      = 1'b1;
                    state_nxt_s = ST_HOLDOFF;
                end else begin
                    glitch_nxt_s = glitch_r + GW'(1);
                end
            end
            ST_HOLDOFF: begin
                if (timer_r == HOLD_LAST) begin
                    state_nxt_s = ST_UNLOCKED;
                    timer_nxt_s = {TW{1'b0}};
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_UNLOCKED;
                timer_nxt_s = {TW{1'b0}};
            end
        endcase
    end

    // State, timers and registered outputs; pll_locked tracks the state it enters.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_r      <= ST_UNLOCKED;
            timer_r      <= {TW{1'b0}};
            glitch_r     <= {GW{1'b0}};
            pll_locked_r <= 1'b0;
            lock_lost_r  <= 1'b0;
            count_r      <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            timer_r      <= timer_nxt_s;
            glitch_r     <= glitch_nxt_s;
            pll_locked_r <= (state_nxt_s == ST_LOCKED);
            lock_lost_r  <= loss_s;
            count_r      <= count_next(count_r, bus.clear_count, loss_s);
        end
    end

    assign bus.pll_locked      = pll_locked_r;
    assign bus.lock_lost       = lock_lost_r;
    assign bus.lock_loss_count = count_r;
    assign bus.state           = state_r;
endmodule

// File: tb/tb_pll_lock_qualifier.sv
// Scoreboard bench for pll_lock_qualifier: each scenario queues expected
// outputs keyed by edge number and checks them as the edges occur.
module tb_pll_lock_qualifier;
    localparam int SYNC  = 2;
    localparam int LOCK  = 16;
    localparam int GLT   = 4;
    localparam int HOLD  = 8;
    localparam int CW    = 2;

    typedef struct {
        int          cyc;
        logic        lk;
        logic [1:0]  st;
        logic [CW-1:0] cnt;
        logic        lost;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic sync_reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   loss_cyc = 0;
    exp_t exp_q[$];

    pll_lock_qualifier_if #(.CNT_WIDTH(CW)) ifc ();

    pll_lock_qualifier #(
        .SYNC_STAGE(SYNC), .LOCK_CYCLES(LOCK), .GLITCH_CYCLES(GLT),
        .HOLDOFF_CYCLES(HOLD), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .sync_reset(sync_reset),
        .bus(ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic expect_at(input int c, input logic lk, input logic [1:0] st,
                             input logic [CW-1:0] cnt, input logic lost, input string tag);
        exp_t e;
        e.cyc = c; e.lk = lk; e.st = st; e.cnt = cnt; e.lost = lost; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        ifc.pll_locked_raw = 1'b0;
        ifc.clear_count    = 1'b0;
        sync_reset         = 1'b1;
        for (int n = 1; n <= 4; n++) expect_at(cyc + n, 1'b0, 2'd0, 2'd0, 1'b0, "reset");
        for (int n = 1; n <= 4; n++) begin
            if (n == 4) sync_reset = 1'b0;
            tick();
            while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front(); n_cmp++;
                if ({ifc.pll_locked, ifc.state, ifc.lock_loss_count, ifc.lock_lost} !== {e.lk, e.st, e.cnt, e.lost}) begin
                    n_bad++;
                    $display("FAIL %s edge=%0d got lk=%b st=%0d cnt=%0d lost=%b expected lk=%b st=%0d cnt=%0d lost=%b",
                             e.tag, cyc, ifc.pll_locked, ifc.state, ifc.lock_loss_count, ifc.lock_lost, e.lk, e.st, e.cnt, e.lost);
                end
            end
        end
    endtask

    // Raw tied high: lock at E0 + SYNC + LOCK, E0 being the first edge sampling high.
    task automatic test_tied_high();
        exp_t e;
        int c = cyc;
        for (int n = 1; n <= 19; n++)
            expect_at(c + n, (n == 19), (n < 3) ? 2'd0 : (n < 19) ? 2'd1 : 2'd2, 2'd0, 1'b0, "tied_high");
        ifc.pll_locked_raw = 1'b1;
        for (int n = 1; n <= 19; n++) begin
            tick();
            while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front(); n_cmp++;
                if ({ifc.pll_locked, ifc.state, ifc.lock_loss_count, ifc.lock_lost} !== {e.lk, e.st, e.cnt, e.lost}) begin
                    n_bad++;
                    $display("FAIL %s edge=%0d got lk=%b st=%0d cnt=%0d lost=%b expected lk=%b st=%0d cnt=%0d lost=%b",
                             e.tag, cyc, ifc.pll_locked, ifc.state, ifc.lock_loss_count, ifc.lock_lost, e.lk, e.st, e.cnt, e.lost);
                end
            end
        end
    endtask

    // Raw high 10 edges, low 1 edge, then high: no partial credit survives the dip.
    task automatic test_aborted();
        exp_t e;
        int c;
        ifc.pll_locked_raw = 1'b0;
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        c = cyc;
        for (int n = 1; n <= 30; n++)
            expect_at(c + n, (n >= 30),
                      (n < 3) ? 2'd0 : (n < 13) ? 2'd1 : (n == 13) ? 2'd0 : (n < 30) ? 2'd1 : 2'd2,
                      2'd0, 1'b0, "aborted");
        for (int k = 0; k < 30; k++) begin
            ifc.pll_locked_raw = (k + 1 != 11);
            tick();
            while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front(); n_cmp++;
                if ({ifc.pll_locked, ifc.state, ifc.lock_loss_count, ifc.lock_lost} !== {e.lk, e.st, e.cnt, e.lost}) begin
                    n_bad++;
                    $display("FAIL %s edge=%0d got lk=%b st=%0d cnt=%0d lost=%b expected lk=%b st=%0d cnt=%0d lost=%b",
                             e.tag, cyc, ifc.pll_locked, ifc.state, ifc.lock_loss_count, ifc.lock_lost, e.lk, e.st, e.cnt, e.lost);
                end
            end
        end
    endtask

    // 3-edge dip is filtered; 4-edge dip starting at edge g+9 drops lock at g+9+5.
    task automatic test_glitch();
        exp_t e;
        int g = cyc;
        for (int n = 1; n <= 13; n++) expect_at(g + n, 1'b1, 2'd2, 2'd0, 1'b0, "glitch_hold");
        expect_at(g + 14, 1'b0, 2'd3, 2'd1, 1'b1, "glitch_loss");
        expect_at(g + 15, 1'b0, 2'd3, 2'd1, 1'b0, "glitch_pulse_end");
        for (int k = 0; k < 15; k++) begin
            ifc.pll_locked_raw = !(((k + 1) >= 1 && (k + 1) <= 3) || ((k + 1) >= 9 && (k + 1) <= 12));
            tick();
            while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front(); n_cmp++;
                if ({ifc.pll_locked, ifc.state, ifc.lock_loss_count, ifc.lock_lost} !== {e.lk, e.st, e.cnt, e.lost}) begin
                    n_bad++;
                    $display("FAIL %s edge=%0d got lk=%b st=%0d cnt=%0d lost=%b expected lk=%b st=%0d cnt=%0d lost=%b",
                             e.tag, cyc, ifc.pll_locked, ifc.state, ifc.lock_loss_count, ifc.lock_lost, e.lk, e.st, e.cnt, e.lost);
                end
            end
        end
        loss_cyc = g + 14;
    endtask

    // After the loss edge L: HOLDOFF for 8 edges, UNLOCKED 1, QUALIFY 16, lock at L+25.
    task automatic test_holdoff();
        exp_t e;
        ifc.pll_locked_raw = 1'b1;
        for (int m = cyc - loss_cyc + 1; m <= 25; m++)
            expect_at(loss_cyc + m, (m == 25),
                      (m < 8) ? 2'd3 : (m == 8) ? 2'd0 : (m < 25) ? 2'd1 : 2'd2,
                      2'd1, 1'b0, "holdoff");
        while (cyc < loss_cyc + 25) begin
            tick();
            while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front(); n_cmp++;
                if ({ifc.pll_locked, ifc.state, ifc.lock_loss_count, ifc.lock_lost} !== {e.lk, e.st, e.cnt, e.lost}) begin
                    n_bad++;
                    $display("FAIL %s edge=%0d got lk=%b st=%0d cnt=%0d lost=%b expected lk=%b st=%0d cnt=%0d lost=%b",
                             e.tag, cyc, ifc.pll_locked, ifc.state, ifc.lock_loss_count, ifc.lock_lost, e.lk, e.st, e.cnt, e.lost);
                end
            end
        end
    endtask

    // One full loss/relock cycle from LOCKED: 4-edge dip, loss at s+6, relock at s+31.
    task automatic test_loss_period(input logic [CW-1:0] cnt_before, input logic [CW-1:0] cnt_after,
                                    input logic clr, input string tag);
        exp_t e;
        int s = cyc;
        for (int n = 1; n <= 5; n++) expect_at(s + n, 1'b1, 2'd2, cnt_before, 1'b0, tag);
        expect_at(s + 6,  1'b0, 2'd3, cnt_after, 1'b1, tag);
        expect_at(s + 7,  1'b0, 2'd3, cnt_after, 1'b0, tag);
        expect_at(s + 30, 1'b0, 2'd1, cnt_after, 1'b0, tag);
        expect_at(s + 31, 1'b1, 2'd2, cnt_after, 1'b0, tag);
        for (int k = 0; k < 31; k++) begin
            ifc.pll_locked_raw = (k > 3);
            ifc.clear_count    = clr && (k == 5);
            tick();
            while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front(); n_cmp++;
                if ({ifc.pll_locked, ifc.state, ifc.lock_loss_count, ifc.lock_lost} !== {e.lk, e.st, e.cnt, e.lost}) begin
                    n_bad++;
                    $display("FAIL %s edge=%0d got lk=%b st=%0d cnt=%0d lost=%b expected lk=%b st=%0d cnt=%0d lost=%b",
                             e.tag, cyc, ifc.pll_locked, ifc.state, ifc.lock_loss_count, ifc.lock_lost, e.lk, e.st, e.cnt, e.lost);
                end
            end
        end
        ifc.clear_count = 1'b0;
    endtask

    // Reset pulse while LOCKED with count=2, then requalify with raw high.
    task automatic test_reset_mid();
        exp_t e;
        int r;
        test_loss_period(2'd1, 2'd2, 1'b0, "pre_reset_loss");
        r = cyc;
        expect_at(r + 1, 1'b0, 2'd0, 2'd0, 1'b0, "reset_mid");
        for (int n = 2; n <= 20; n++)
            expect_at(r + n, (n == 20), (n < 4) ? 2'd0 : (n < 20) ? 2'd1 : 2'd2, 2'd0, 1'b0, "relock_after_reset");
        ifc.pll_locked_raw = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            sync_reset = (n == 1);
            tick();
            while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front(); n_cmp++;
                if ({ifc.pll_locked, ifc.state, ifc.lock_loss_count, ifc.lock_lost} !== {e.lk, e.st, e.cnt, e.lost}) begin
                    n_bad++;
                    $display("FAIL %s edge=%0d got lk=%b st=%0d cnt=%0d lost=%b expected lk=%b st=%0d cnt=%0d lost=%b",
                             e.tag, cyc, ifc.pll_locked, ifc.state, ifc.lock_loss_count, ifc.lock_lost, e.lk, e.st, e.cnt, e.lost);
                end
            end
        end
        sync_reset = 1'b0;
    endtask

    // Counter saturates at 3, clear coincident with a loss gives 1, clear alone gives 0.
    task automatic test_saturation();
        exp_t e;
        int s;
        test_loss_period(2'd0, 2'd1, 1'b0, "sat_loss1");
        test_loss_period(2'd1, 2'd2, 1'b0, "sat_loss2");
        test_loss_period(2'd2, 2'd3, 1'b0, "sat_loss3");
        test_loss_period(2'd3, 2'd3, 1'b0, "sat_loss4");
        test_loss_period(2'd3, 2'd3, 1'b0, "sat_loss5");
        test_loss_period(2'd3, 2'd1, 1'b1, "clear_with_loss");
        s = cyc;
        expect_at(s + 1, 1'b1, 2'd2, 2'd0, 1'b0, "clear_alone");
        expect_at(s + 2, 1'b1, 2'd2, 2'd0, 1'b0, "clear_alone_hold");
        for (int n = 1; n <= 2; n++) begin
            ifc.clear_count = (n == 1);
            tick();
            while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front(); n_cmp++;
                if ({ifc.pll_locked, ifc.state, ifc.lock_loss_count, ifc.lock_lost} !== {e.lk, e.st, e.cnt, e.lost}) begin
                    n_bad++;
                    $display("FAIL %s edge=%0d got lk=%b st=%0d cnt=%0d lost=%b expected lk=%b st=%0d cnt=%0d lost=%b",
                             e.tag, cyc, ifc.pll_locked, ifc.state, ifc.lock_loss_count, ifc.lock_lost, e.lk, e.st, e.cnt, e.lost);
                end
            end
        end
        ifc.clear_count = 1'b0;
    endtask

    initial begin
        sync_reset         = 1'b1;
        ifc.pll_locked_raw = 1'b0;
        ifc.clear_count    = 1'b0;
        test_reset();
        test_tied_high();
        test_aborted();
        test_glitch();
        test_holdoff();
        test_reset_mid();
        test_saturation();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d pending expected 0 pending", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
